// File: rtl/sc_countdown_pkg.sv
// Shared definitions for the prescaled countdown timer.
// State encodings are fixed so they stay aligned with the rest of the counter codebase.
package sc_countdown_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } sc_countdown_state_e;

endpackage

// File: rtl/sc_prescaler.sv
// Clock-cycle prescaler: counts enabled cycles and emits a tick on the last cycle of each interval.
module sc_prescaler #(
    parameter int unsigned PRESCALE_DIV   = 4,
    parameter int unsigned PRESCALE_WIDTH = 20
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [PRESCALE_WIDTH-1:0] Last = PRESCALE_WIDTH'(PRESCALE_DIV - 1);
    localparam logic [PRESCALE_WIDTH-1:0] One  = PRESCALE_WIDTH'(1);

    logic [PRESCALE_WIDTH-1:0] cnt_d, cnt_q;

    // Tick is combinational so the owner acts on it in the same cycle the count wraps.
    always_comb begin
        cnt_d  = cnt_q;
        tick_o = en_i && !clr_i && (cnt_q == Last);
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + One;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sc_countdown_timer.sv
// Loadable prescaled down-counter with expiry pulse and zero flag.
// Define SC_COUNTDOWN_AUTORELOAD_EN to reload from the last loaded value instead of stopping.
module sc_countdown_timer
    import sc_countdown_pkg::*;
#(
    parameter int unsigned COUNTER_DATAWIDTH = 8,
    parameter int unsigned PRESCALE_DIV      = 4,
    parameter int unsigned PRESCALE_WIDTH    = 20
) (
    input  logic                         SC_COUNTER_CLOCK_50,
    input  logic                         SC_COUNTER_RESET_InHigh,
    input  logic                         SC_COUNTDOWN_load_InLow,
    input  logic [COUNTER_DATAWIDTH-1:0] SC_COUNTDOWN_data_InBUS,
    input  logic                         SC_COUNTDOWN_start_InLow,
    input  logic                         SC_COUNTDOWN_pause_InLow,
    output logic [COUNTER_DATAWIDTH-1:0] SC_COUNTDOWN_data_OutBUS,
    output logic                         SC_COUNTDOWN_running_Out,
    output logic                         SC_COUNTDOWN_zero_Out,
    output logic                         SC_COUNTDOWN_expired_OutPulse
);

    localparam logic [COUNTER_DATAWIDTH-1:0] One = COUNTER_DATAWIDTH'(1);

    sc_countdown_state_e            state_d, state_q;
    logic [COUNTER_DATAWIDTH-1:0]   count_d, count_q;
    logic                           expired_d, expired_q;
    logic                           running_q;
    logic                           presc_clr, presc_en, presc_tick;
`ifdef SC_COUNTDOWN_AUTORELOAD_EN
    logic [COUNTER_DATAWIDTH-1:0]   reload_d, reload_q;
`endif

    sc_prescaler #(
        .PRESCALE_DIV   (PRESCALE_DIV),
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk_i  (SC_COUNTER_CLOCK_50),
        .rst_i  (SC_COUNTER_RESET_InHigh),
        .clr_i  (presc_clr),
        .en_i   (presc_en),
        .tick_o (presc_tick)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        expired_d = 1'b0;
        presc_clr = 1'b0;
        presc_en  = 1'b0;
`ifdef SC_COUNTDOWN_AUTORELOAD_EN
        reload_d  = reload_q;
`endif
        if (!SC_COUNTDOWN_load_InLow) begin
            count_d   = SC_COUNTDOWN_data_InBUS;
            presc_clr = 1'b1;
            state_d   = StIdle;
`ifdef SC_COUNTDOWN_AUTORELOAD_EN
            reload_d  = SC_COUNTDOWN_data_InBUS;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!SC_COUNTDOWN_start_InLow) begin
                        if (count_q != '0) begin
                            state_d   = StRun;
                            presc_clr = 1'b1;
                        end else begin
                            state_d   = StDone;
                            expired_d = 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (!SC_COUNTDOWN_pause_InLow) begin
                        state_d = StPause;
                    end else begin
                        presc_en = 1'b1;
                        if (presc_tick) begin
                            if (count_q > One) begin
                                count_d = count_q - One;
                            end else begin
                                expired_d = 1'b1;
`ifdef SC_COUNTDOWN_AUTORELOAD_EN
                                count_d = reload_q;
                                if (reload_q == '0) begin
                                    state_d = StDone;
                                end
`else
                                count_d = '0;
                                state_d = StDone;
`endif
                            end
                        end
                    end
                end
                StPause: begin
                    if (SC_COUNTDOWN_pause_InLow) begin
                        state_d = StRun;
                    end
                end
                StDone: begin
                    count_d = '0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge SC_COUNTER_CLOCK_50 or posedge SC_COUNTER_RESET_InHigh) begin
        if (SC_COUNTER_RESET_InHigh) begin
            state_q   <= StIdle;
            count_q   <= '0;
            expired_q <= 1'b0;
            running_q <= 1'b0;
`ifdef SC_COUNTDOWN_AUTORELOAD_EN
            reload_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            expired_q <= expired_d;
            running_q <= (state_d == StRun);
`ifdef SC_COUNTDOWN_AUTORELOAD_EN
            reload_q  <= reload_d;
`endif
        end
    end

    assign SC_COUNTDOWN_data_OutBUS      = count_q;
    assign SC_COUNTDOWN_running_Out      = running_q;
    assign SC_COUNTDOWN_zero_Out         = (count_q == '0);
    assign SC_COUNTDOWN_expired_OutPulse = expired_q;

endmodule

// File: tb/tb_sc_countdown_timer.sv
// Self-checking bench for sc_countdown_timer: directed scenarios plus random stimulus vs a cycle model.
module tb_sc_countdown_timer;

    localparam int unsigned W   = 8;
    localparam int unsigned DIV = 4;

    localparam int MIdle  = 0;
    localparam int MRun   = 1;
    localparam int MPause = 2;
    localparam int MDone  = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_n = 1'b1;
    logic [W-1:0] data = '0;
    logic         start_n = 1'b1;
    logic         pause_n = 1'b1;
    logic [W-1:0] count_o;
    logic         running_o, zero_o, expired_o;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int m_count, m_reload, m_phase, m_st;
    bit m_exp;

    always #5 clk = ~clk;

    sc_countdown_timer #(
        .COUNTER_DATAWIDTH (W),
        .PRESCALE_DIV      (DIV),
        .PRESCALE_WIDTH    (20)
    ) dut (
        .SC_COUNTER_CLOCK_50           (clk),
        .SC_COUNTER_RESET_InHigh       (rst),
        .SC_COUNTDOWN_load_InLow       (load_n),
        .SC_COUNTDOWN_data_InBUS       (data),
        .SC_COUNTDOWN_start_InLow      (start_n),
        .SC_COUNTDOWN_pause_InLow      (pause_n),
        .SC_COUNTDOWN_data_OutBUS      (count_o),
        .SC_COUNTDOWN_running_Out      (running_o),
        .SC_COUNTDOWN_zero_Out         (zero_o),
        .SC_COUNTDOWN_expired_OutPulse (expired_o)
    );

    function automatic void model_reset();
        m_count = 0; m_reload = 0; m_phase = 0; m_st = MIdle; m_exp = 0;
    endfunction

    // One clock edge of the timer, from the behavioural rules.
    function automatic void model_step();
        m_exp = 0;
        if (!load_n) begin
            m_count = int'(data); m_reload = int'(data); m_phase = 0; m_st = MIdle;
        end else if (m_st == MIdle) begin
            if (!start_n) begin
                if (m_count != 0) begin m_st = MRun; m_phase = 0; end
                else begin m_st = MDone; m_exp = 1; end
            end
        end else if (m_st == MRun) begin
            if (!pause_n) m_st = MPause;
            else begin
                m_phase++;
                if (m_phase == DIV) begin
                    m_phase = 0;
                    if (m_count > 1) m_count--;
                    else begin
                        m_exp = 1;
`ifdef SC_COUNTDOWN_AUTORELOAD_EN
                        m_count = m_reload;
                        if (m_reload == 0) m_st = MDone;
`else
                        m_count = 0;
                        m_st = MDone;
`endif
                    end
                end
            end
        end else if (m_st == MPause) begin
            if (pause_n) m_st = MRun;
        end
    endfunction

    // Inputs are changed at negedge; the model follows each posedge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; load_n = 1'b1; start_n = 1'b1; pause_n = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec += 4;
        if (count_o !== '0) begin n_err++; $display("FAIL reset_count got %0d want 0", count_o); end
        if (zero_o !== 1'b1) begin n_err++; $display("FAIL reset_zero got %b want 1", zero_o); end
        if (running_o !== 1'b0) begin n_err++; $display("FAIL reset_running got %b want 0", running_o); end
        if (expired_o !== 1'b0) begin n_err++; $display("FAIL reset_expired got %b want 0", expired_o); end
        start_n = 1'b0;
        step();
        start_n = 1'b1;
        n_vec += 2;
        if (expired_o !== 1'b1) begin n_err++; $display("FAIL zero_start_expired got %b want 1", expired_o); end
        if (running_o !== 1'b0) begin n_err++; $display("FAIL zero_start_running got %b want 0", running_o); end
        step();
        n_vec++;
        if (expired_o !== 1'b0) begin n_err++; $display("FAIL zero_start_pulse_len got %b want 0", expired_o); end
    endtask

    task automatic test_oneshot();
        do_reset();
        data = 8'd3; load_n = 1'b0; step(); load_n = 1'b1;
        n_vec++;
        if (count_o !== 8'd3) begin n_err++; $display("FAIL load3 got %0d want 3", count_o); end
        start_n = 1'b0; step(); start_n = 1'b1;
        n_vec++;
        if (running_o !== 1'b1) begin n_err++; $display("FAIL start_running got %b want 1", running_o); end
        for (int c = 1; c <= 3 * DIV + 1; c++) begin
            if (c == 3 * DIV + 1) start_n = 1'b0;
            step();
            n_vec += 3;
            if (count_o !== W'(m_count)) begin
                n_err++; $display("FAIL oneshot_count cyc %0d got %0d want %0d", c, count_o, m_count);
            end
            if (expired_o !== m_exp) begin
                n_err++; $display("FAIL oneshot_expired cyc %0d got %b want %b", c, expired_o, m_exp);
            end
            if (running_o !== (m_st == MRun)) begin
                n_err++; $display("FAIL oneshot_running cyc %0d got %b", c, running_o);
            end
        end
        start_n = 1'b1;
`ifndef SC_COUNTDOWN_AUTORELOAD_EN
        n_vec += 2;
        if (count_o !== '0 || running_o !== 1'b0) begin
            n_err++; $display("FAIL done_ignores_start count %0d running %b want 0 0", count_o, running_o);
        end
        if (zero_o !== 1'b1) begin n_err++; $display("FAIL done_zero got %b want 1", zero_o); end
`endif
    endtask

    task automatic test_pause();
        do_reset();
        data = 8'd5; load_n = 1'b0; step(); load_n = 1'b1;
        start_n = 1'b0; step(); start_n = 1'b1;
        step(); step();
        pause_n = 1'b0;
        for (int c = 0; c < 10; c++) step();
        n_vec += 2;
        if (count_o !== 8'd5) begin n_err++; $display("FAIL pause_frozen got %0d want 5", count_o); end
        if (running_o !== 1'b0) begin n_err++; $display("FAIL pause_running got %b want 0", running_o); end
        pause_n = 1'b1;
        step(); step();
        n_vec++;
        if (count_o !== 8'd5) begin n_err++; $display("FAIL pause_resume_early got %0d want 5", count_o); end
        step();
        n_vec++;
        if (count_o !== 8'd4) begin n_err++; $display("FAIL pause_resume_tick got %0d want 4", count_o); end
    endtask

    task automatic test_load_mid_run();
        do_reset();
        data = 8'd6; load_n = 1'b0; step(); load_n = 1'b1;
        start_n = 1'b0; step(); start_n = 1'b1;
        for (int c = 0; c < DIV - 1; c++) step();
        data = 8'd9; load_n = 1'b0; step(); load_n = 1'b1;
        n_vec += 3;
        if (count_o !== 8'd9) begin n_err++; $display("FAIL load_mid_count got %0d want 9", count_o); end
        if (running_o !== 1'b0) begin n_err++; $display("FAIL load_mid_running got %b want 0", running_o); end
        if (expired_o !== 1'b0) begin n_err++; $display("FAIL load_mid_expired got %b want 0", expired_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        data = 8'd7; load_n = 1'b0; step(); load_n = 1'b1;
        start_n = 1'b0; step(); start_n = 1'b1;
        step();
        #2 rst = 1'b1;
        #1;
        n_vec += 3;
        if (count_o !== '0) begin n_err++; $display("FAIL async_rst_count got %0d want 0", count_o); end
        if (running_o !== 1'b0) begin n_err++; $display("FAIL async_rst_running got %b want 0", running_o); end
        if (zero_o !== 1'b1) begin n_err++; $display("FAIL async_rst_zero got %b want 1", zero_o); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            load_n  = ($urandom_range(0, 15) != 0);
            data    = W'($urandom_range(0, 6));
            start_n = ($urandom_range(0, 7) != 0);
            pause_n = ($urandom_range(0, 5) != 0);
            step();
            n_vec += 4;
            if (count_o !== W'(m_count)) begin
                n_err++; $display("FAIL rand_count cyc %0d got %0d want %0d", c, count_o, m_count);
            end
            if (zero_o !== (m_count == 0)) begin
                n_err++; $display("FAIL rand_zero cyc %0d got %b", c, zero_o);
            end
            if (running_o !== (m_st == MRun)) begin
                n_err++; $display("FAIL rand_running cyc %0d got %b want %b", c, running_o, m_st == MRun);
            end
            if (expired_o !== m_exp) begin
                n_err++; $display("FAIL rand_expired cyc %0d got %b want %b", c, expired_o, m_exp);
            end
        end
        load_n = 1'b1; start_n = 1'b1; pause_n = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_oneshot();
        test_pause();
        test_load_mid_run();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
